fpd_share_ctrl: RTL and testbench

Sequencer and round-robin arbiter that shares one combinational 32-bit IEEE-754 single-precision divider (`FPD_32`) between `N_REQ` requesters. It accepts one division at a time over a valid/ready handshake and drives the divider's operand inputs from registers. The divider is treated as a multicycle path: operands are held stable for `HOLD_CYCLES` cycles before the quotient is registered. The result is returned on a single response channel tagged with the requester index. The block sits between client datapaths and the single `FPD_32` instance, which is instantiated outside it.

---
 rtl/fpd_share_ctrl_pkg.sv | 16 +
 rtl/fpd_share_ctrl_rr_arbiter.sv | 33 +++
 rtl/fpd_share_ctrl.sv | 122 ++++++++++++
 tb/tb_fpd_share_ctrl.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpd_share_ctrl_pkg.sv
// rtl/fpd_share_ctrl_pkg.sv - shared types and FP32 constants for the divider share controller
package fpd_share_ctrl_pkg;

  localparam int FP32_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } fpd_state_e;

  localparam logic [FP32_W-1:0] FP_ONE  = 32'h3F80_0000;
  localparam logic [FP32_W-1:0] FP_TWO  = 32'h4000_0000;
  localparam logic [FP32_W-1:0] FP_QNAN = 32'h7FC0_0000;

endpackage

// File: rtl/fpd_share_ctrl_rr_arbiter.sv
// rtl/fpd_share_ctrl_rr_arbiter.sv - combinational round-robin picker starting after last_grant
module fpd_share_ctrl_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last_grant,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_idx,
  output logic             grant_any
);

  logic [ID_W-1:0] idx;

  // Walk from the farthest candidate to the nearest so the nearest requester wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = ID_W'((int'(last_grant) + k) % N_REQ);
      if (req[idx]) begin
        grant_idx = idx;
        grant_any = 1'b1;
      end
    end
    if (grant_any) begin
      grant[grant_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/fpd_share_ctrl.sv
// rtl/fpd_share_ctrl.sv - shares one combinational FP32 divider between N_REQ requesters
module fpd_share_ctrl
  import fpd_share_ctrl_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int HOLD_CYCLES = 3,
  parameter int ID_W        = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [FP32_W*N_REQ-1:0] req_dividend,
  input  logic [FP32_W*N_REQ-1:0] req_divisor,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [FP32_W-1:0]       resp_quotient,
  output logic [ID_W-1:0]         resp_id,
  output logic [FP32_W-1:0]       fpd_dividend,
  output logic [FP32_W-1:0]       fpd_divisor,
  input  logic [FP32_W-1:0]       fpd_quotient
);

  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  fpd_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [ID_W-1:0]   last_grant_q;
  logic [N_REQ-1:0]  grant;
  logic [ID_W-1:0]   grant_idx;
  logic              grant_any;
  logic [FP32_W-1:0] dividend_slice [N_REQ];
  logic [FP32_W-1:0] divisor_slice  [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign dividend_slice[i] = req_dividend[FP32_W*i +: FP32_W];
    assign divisor_slice[i]  = req_divisor[FP32_W*i +: FP32_W];
  end

  fpd_share_ctrl_rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .grant_any  (grant_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    case (state_q)
      ST_IDLE: begin
        if (grant_any) begin
          req_ready = grant;
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Operands stay parked on the divider until the next accept; the quotient is sampled once.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= '0;
      last_grant_q  <= ID_W'(N_REQ - 1);
      resp_valid    <= 1'b0;
      resp_quotient <= '0;
      resp_id       <= '0;
      fpd_dividend  <= '0;
      fpd_divisor   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant_any) begin
            fpd_dividend <= dividend_slice[grant_idx];
            fpd_divisor  <= divisor_slice[grant_idx];
            resp_id      <= grant_idx;
            last_grant_q <= grant_idx;
            cnt_q        <= CNT_W'(HOLD_CYCLES - 1);
          end
        end
        ST_WAIT: begin
          if (cnt_q == '0) begin
            resp_quotient <= fpd_quotient;
            resp_valid    <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpd_share_ctrl.sv
// tb/tb_fpd_share_ctrl.sv - self-checking bench for fpd_share_ctrl with a stand-in divider
`timescale 1ns/1ps
module tb_fpd_share_ctrl;
  import fpd_share_ctrl_pkg::*;

  localparam int N    = 4;
  localparam int HOLD = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [N-1:0]  req_valid, req_ready;
  logic [31:0]   dvd [N];
  logic [31:0]   dvs [N];
  logic [32*N-1:0] req_dividend, req_divisor;
  logic          resp_valid, resp_ready;
  logic [31:0]   resp_quotient;
  logic [1:0]    resp_id;
  logic [31:0]   fpd_dividend, fpd_divisor, fpd_quotient;

  logic [N-1:0]    req_valid_h1, req_ready_h1;
  logic [32*N-1:0] req_dividend_h1, req_divisor_h1;
  logic            resp_valid_h1, resp_ready_h1;
  logic [31:0]     resp_quotient_h1;
  logic [1:0]      resp_id_h1;
  logic [31:0]     fpd_dividend_h1, fpd_divisor_h1, fpd_quotient_h1;

  int n_pass;
  int n_total;

  // Stand-in for FPD_32: exact on the known cases, an arbitrary bijection-like mix otherwise.
  function automatic logic [31:0] fdiv(input logic [31:0] a, input logic [31:0] b);
    if (a == FP_ONE && b == FP_TWO) return 32'h3F00_0000;
    if (a == 32'h40C0_0000 && b == FP_TWO) return 32'h4040_0000;
    if (b == 32'h0) return FP_QNAN;
    return (a ^ {b[15:0], b[31:16]}) + 32'h1357_9BDF;
  endfunction

  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  for (genvar gi = 0; gi < N; gi++) begin : g_pack
    assign req_dividend[32*gi +: 32] = dvd[gi];
    assign req_divisor[32*gi +: 32]  = dvs[gi];
  end

  assign fpd_quotient    = fdiv(fpd_dividend, fpd_divisor);
  assign fpd_quotient_h1 = fdiv(fpd_dividend_h1, fpd_divisor_h1);

  fpd_share_ctrl #(.N_REQ(N), .HOLD_CYCLES(HOLD), .ID_W(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_dividend  (req_dividend),
    .req_divisor   (req_divisor),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_quotient (resp_quotient),
    .resp_id       (resp_id),
    .fpd_dividend  (fpd_dividend),
    .fpd_divisor   (fpd_divisor),
    .fpd_quotient  (fpd_quotient)
  );

  fpd_share_ctrl #(.N_REQ(N), .HOLD_CYCLES(1), .ID_W(2)) dut_h1 (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid_h1),
    .req_ready     (req_ready_h1),
    .req_dividend  (req_dividend_h1),
    .req_divisor   (req_divisor_h1),
    .resp_valid    (resp_valid_h1),
    .resp_ready    (resp_ready_h1),
    .resp_quotient (resp_quotient_h1),
    .resp_id       (resp_id_h1),
    .fpd_dividend  (fpd_dividend_h1),
    .fpd_divisor   (fpd_divisor_h1),
    .fpd_quotient  (fpd_quotient_h1)
  );

  task automatic apply_reset();
    rst = 1'b1;
    req_valid = '0;
    req_valid_h1 = '0;
    resp_ready = 1'b1;
    resp_ready_h1 = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    n_total++; if (req_ready !== 4'b0000) $display("FAIL reset_req_ready got=%b exp=0000", req_ready); else n_pass++;
    n_total++; if (resp_valid !== 1'b0) $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); else n_pass++;
    n_total++; if (resp_quotient !== 32'h0) $display("FAIL reset_resp_quotient got=%h exp=0", resp_quotient); else n_pass++;
    n_total++; if (resp_id !== 2'd0) $display("FAIL reset_resp_id got=%0d exp=0", resp_id); else n_pass++;
    n_total++; if (fpd_dividend !== 32'h0) $display("FAIL reset_fpd_dividend got=%h exp=0", fpd_dividend); else n_pass++;
    n_total++; if (fpd_divisor !== 32'h0) $display("FAIL reset_fpd_divisor got=%h exp=0", fpd_divisor); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_single_op();
    int lat;
    dvd[1] = FP_ONE;
    dvs[1] = FP_TWO;
    req_valid = 4'b0010;
    resp_ready = 1'b1;
    @(negedge clk);
    n_total++; if (req_ready !== 4'b0010) $display("FAIL single_grant got=%b exp=0010", req_ready); else n_pass++;
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk);
    n_total++; if (fpd_dividend !== FP_ONE || fpd_divisor !== FP_TWO)
      $display("FAIL single_operands got=%h/%h exp=%h/%h", fpd_dividend, fpd_divisor, FP_ONE, FP_TWO); else n_pass++;
    lat = 0;
    while (!resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    n_total++; if (lat !== HOLD) $display("FAIL single_latency got=%0d exp=%0d", lat, HOLD); else n_pass++;
    n_total++; if (resp_quotient !== 32'h3F00_0000) $display("FAIL single_quotient got=%h exp=3f000000", resp_quotient); else n_pass++;
    n_total++; if (resp_id !== 2'd1) $display("FAIL single_id got=%0d exp=1", resp_id); else n_pass++;
    @(posedge clk); #1;
    @(negedge clk);
    n_total++; if (resp_valid !== 1'b0) $display("FAIL single_release got=%b exp=0", resp_valid); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_fairness();
    int acc, cyc, prev, ref_last, g;
    logic [31:0] q_exp [$];
    int          id_exp [$];
    logic [N-1:0] exp_rr;
    apply_reset();
    for (int i = 0; i < N; i++) begin
      dvd[i] = 32'h3F80_0000 + (i << 16);
      dvs[i] = 32'h4000_0000 + i + 1;
    end
    req_valid = '1;
    resp_ready = 1'b1;
    ref_last = N - 1;
    acc = 0; cyc = 0; prev = -1;
    while (acc < 5 && cyc < 80) begin
      @(negedge clk);
      if (req_ready != '0) begin
        g = rr_pick(req_valid, ref_last);
        exp_rr = '0;
        exp_rr[g] = 1'b1;
        n_total++; if (req_ready !== exp_rr) $display("FAIL fair_grant got=%b exp=%b", req_ready, exp_rr); else n_pass++;
        if (prev >= 0) begin
          n_total++; if (cyc - prev !== HOLD + 2) $display("FAIL fair_spacing got=%0d exp=%0d", cyc - prev, HOLD + 2); else n_pass++;
        end
        prev = cyc;
        ref_last = g;
        acc++;
        q_exp.push_back(fdiv(dvd[g], dvs[g]));
        id_exp.push_back(g);
      end
      if (resp_valid && resp_ready) begin
        n_total++;
        if (q_exp.size() == 0) $display("FAIL fair_resp got=unexpected_response exp=none");
        else if (resp_id !== 2'(id_exp[0]) || resp_quotient !== q_exp[0])
          $display("FAIL fair_resp got=%0d/%h exp=%0d/%h", resp_id, resp_quotient, id_exp[0], q_exp[0]);
        else n_pass++;
        if (q_exp.size() != 0) begin
          void'(q_exp.pop_front());
          void'(id_exp.pop_front());
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    n_total++; if (acc !== 5) $display("FAIL fair_accepts got=%0d exp=5", acc); else n_pass++;
    req_valid = '0;
    for (int k = 0; k < 20 && q_exp.size() != 0; k++) begin
      @(negedge clk);
      if (resp_valid) begin
        n_total++;
        if (resp_id !== 2'(id_exp[0]) || resp_quotient !== q_exp[0])
          $display("FAIL fair_drain got=%0d/%h exp=%0d/%h", resp_id, resp_quotient, id_exp[0], q_exp[0]);
        else n_pass++;
        void'(q_exp.pop_front());
        void'(id_exp.pop_front());
      end
      @(posedge clk); #1;
    end
    n_total++; if (q_exp.size() !== 0) $display("FAIL fair_outstanding got=%0d exp=0", q_exp.size()); else n_pass++;
  endtask

  task automatic test_backpressure();
    int waited;
    resp_ready = 1'b0;
    dvd[3] = 32'h40C0_0000;
    dvs[3] = FP_TWO;
    dvd[0] = 32'h1234_5678;
    dvs[0] = 32'h0BAD_F00D;
    req_valid = 4'b1000;
    @(negedge clk);
    n_total++; if (req_ready !== 4'b1000) $display("FAIL bp_grant got=%b exp=1000", req_ready); else n_pass++;
    @(posedge clk); #1 req_valid = 4'b0001;
    waited = 0;
    @(negedge clk);
    while (!resp_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    for (int k = 0; k < 10; k++) begin
      n_total++; if (resp_valid !== 1'b1) $display("FAIL bp_valid_held got=%b exp=1", resp_valid); else n_pass++;
      n_total++; if (resp_quotient !== 32'h4040_0000) $display("FAIL bp_quotient got=%h exp=40400000", resp_quotient); else n_pass++;
      n_total++; if (resp_id !== 2'd3) $display("FAIL bp_id got=%0d exp=3", resp_id); else n_pass++;
      n_total++; if (req_ready !== 4'b0000) $display("FAIL bp_no_grant got=%b exp=0000", req_ready); else n_pass++;
      @(posedge clk); #1;
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_total++; if (resp_valid !== 1'b0) $display("FAIL bp_release got=%b exp=0", resp_valid); else n_pass++;
    n_total++; if (req_ready !== 4'b0001) $display("FAIL bp_next_grant got=%b exp=0001", req_ready); else n_pass++;
    req_valid = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_withdrawn();
    int seen2, nresp, ngrant0;
    logic [31:0] q0;
    dvd[0] = $urandom;
    dvs[0] = $urandom | 32'h1;
    dvd[2] = $urandom;
    dvs[2] = $urandom;
    q0 = fdiv(dvd[0], dvs[0]);
    resp_ready = 1'b1;
    seen2 = 0; nresp = 0; ngrant0 = 0;
    for (int c = 0; c < 16; c++) begin
      req_valid = (c == 0) ? 4'b0001 : (c == 2) ? 4'b0100 : 4'b0000;
      @(negedge clk);
      if (req_ready[2]) seen2++;
      if (req_ready[0]) ngrant0++;
      if (resp_valid && resp_ready) begin
        nresp++;
        n_total++; if (resp_id !== 2'd0 || resp_quotient !== q0)
          $display("FAIL wd_resp got=%0d/%h exp=0/%h", resp_id, resp_quotient, q0); else n_pass++;
      end
      @(posedge clk); #1;
    end
    req_valid = '0;
    n_total++; if (seen2 !== 0) $display("FAIL wd_req2_granted got=%0d exp=0", seen2); else n_pass++;
    n_total++; if (ngrant0 !== 1) $display("FAIL wd_grant0_count got=%0d exp=1", ngrant0); else n_pass++;
    n_total++; if (nresp !== 1) $display("FAIL wd_resp_count got=%0d exp=1", nresp); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int stray;
    dvd[2] = $urandom | 32'h8000_0000;
    dvs[2] = $urandom | 32'h0000_0001;
    resp_ready = 1'b1;
    req_valid = 4'b0100;
    @(negedge clk);
    n_total++; if (req_ready !== 4'b0100) $display("FAIL rm_grant got=%b exp=0100", req_ready); else n_pass++;
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk);
    n_total++; if (fpd_dividend !== dvd[2]) $display("FAIL rm_loaded got=%h exp=%h", fpd_dividend, dvd[2]); else n_pass++;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_total++; if (resp_valid !== 1'b0) $display("FAIL rm_resp_valid got=%b exp=0", resp_valid); else n_pass++;
    n_total++; if (fpd_dividend !== 32'h0) $display("FAIL rm_fpd_dividend got=%h exp=0", fpd_dividend); else n_pass++;
    n_total++; if (fpd_divisor !== 32'h0) $display("FAIL rm_fpd_divisor got=%h exp=0", fpd_divisor); else n_pass++;
    stray = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (resp_valid) stray++;
    end
    n_total++; if (stray !== 0) $display("FAIL rm_stray_resp got=%0d exp=0", stray); else n_pass++;
    req_valid = '1;
    #1;
    n_total++; if (req_ready !== 4'b0001) $display("FAIL rm_next_grant got=%b exp=0001", req_ready); else n_pass++;
    req_valid = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int last, due, exp_id, w, nacc, nresp;
    bit busy, exp_rv;
    logic [31:0]  exp_q;
    logic [N-1:0] exp_rr, acc_mask;
    apply_reset();
    last = N - 1; busy = 0; due = 0; exp_id = 0; exp_q = '0;
    nacc = 0; nresp = 0; acc_mask = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (acc_mask[i]) req_valid[i] = 1'b0;
        else if (req_valid[i]) begin
          if ($urandom_range(7) == 0) req_valid[i] = 1'b0;
        end else if ($urandom_range(2) == 0) begin
          req_valid[i] = 1'b1;
          dvd[i] = $urandom;
          dvs[i] = $urandom;
        end
      end
      resp_ready = ($urandom_range(9) < 7);
      @(negedge clk);
      w = rr_pick(req_valid, last);
      exp_rr = '0;
      if (!busy && w >= 0) exp_rr[w] = 1'b1;
      exp_rv = busy && (c >= due);
      n_total++; if (req_ready !== exp_rr) $display("FAIL rnd_req_ready cyc=%0d got=%b exp=%b", c, req_ready, exp_rr); else n_pass++;
      n_total++; if (resp_valid !== exp_rv) $display("FAIL rnd_resp_valid cyc=%0d got=%b exp=%b", c, resp_valid, exp_rv); else n_pass++;
      if (exp_rv && resp_valid) begin
        n_total++; if (resp_id !== 2'(exp_id) || resp_quotient !== exp_q)
          $display("FAIL rnd_resp cyc=%0d got=%0d/%h exp=%0d/%h", c, resp_id, resp_quotient, exp_id, exp_q); else n_pass++;
      end
      acc_mask = exp_rr;
      if (exp_rr != '0) begin
        busy = 1; due = c + HOLD + 1; exp_id = w; exp_q = fdiv(dvd[w], dvs[w]); last = w; nacc++;
      end else if (exp_rv && resp_ready) begin
        busy = 0; nresp++;
      end
      @(posedge clk); #1;
    end
    req_valid = '0;
    resp_ready = 1'b1;
    n_total++; if (nacc < 20) $display("FAIL rnd_activity got=%0d exp>=20", nacc); else n_pass++;
    repeat (HOLD + 3) @(posedge clk);
    #1;
  endtask

  task automatic test_hold1();
    int lat;
    req_dividend_h1 = '0;
    req_divisor_h1  = '0;
    req_dividend_h1[63:32] = FP_ONE;
    req_divisor_h1[63:32]  = FP_TWO;
    resp_ready_h1 = 1'b1;
    req_valid_h1 = 4'b0010;
    @(negedge clk);
    n_total++; if (req_ready_h1 !== 4'b0010) $display("FAIL h1_grant got=%b exp=0010", req_ready_h1); else n_pass++;
    @(posedge clk); #1 req_valid_h1 = '0;
    @(negedge clk);
    n_total++; if (fpd_dividend_h1 !== FP_ONE) $display("FAIL h1_operand got=%h exp=%h", fpd_dividend_h1, FP_ONE); else n_pass++;
    lat = 0;
    while (!resp_valid_h1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    n_total++; if (lat !== 1) $display("FAIL h1_latency got=%0d exp=1", lat); else n_pass++;
    n_total++; if (resp_quotient_h1 !== 32'h3F00_0000) $display("FAIL h1_quotient got=%h exp=3f000000", resp_quotient_h1); else n_pass++;
    n_total++; if (resp_id_h1 !== 2'd1) $display("FAIL h1_id got=%0d exp=1", resp_id_h1); else n_pass++;
    @(posedge clk); #1;
    @(negedge clk);
    n_total++; if (resp_valid_h1 !== 1'b0) $display("FAIL h1_release got=%b exp=0", resp_valid_h1); else n_pass++;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    n_pass = 0;
    n_total = 0;
    rst = 1'b1;
    req_valid = '0;
    resp_ready = 1'b1;
    req_valid_h1 = '0;
    resp_ready_h1 = 1'b1;
    req_dividend_h1 = '0;
    req_divisor_h1 = '0;
    for (int i = 0; i < N; i++) begin
      dvd[i] = '0;
      dvs[i] = '0;
    end
    test_reset();
    test_single_op();
    test_fairness();
    test_backpressure();
    test_withdrawn();
    test_reset_mid();
    test_random();
    test_hold1();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
